// File: rtl/im_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Latency: n/a (declarations only).
// Backpressure: n/a. IM_LOADER_CHECKSUM_EN adds the CSUM state to the enum.
package im_pkg;

    localparam int IM_WORD_W        = 32;
    localparam int IM_DEPTH_DEFAULT = 32;

    // Loader FSM states; CSUM only exists when the trailing checksum byte is in use.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        FIN  = 3'd3
`ifdef IM_LOADER_CHECKSUM_EN
        ,
        CSUM = 3'd4
`endif
    } im_state_t;

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// Latency: n/a (wiring only).
// Backpressure: in_ready gates the byte stream; the write port has none.
interface im_loader_if #(
    parameter int ADDR_W = 5
);
    import im_pkg::*;

    logic                 in_valid;
    logic [7:0]           in_byte;
    logic                 in_ready;
    logic                 im_we;
    logic [ADDR_W-1:0]    im_addr;
    logic [IM_WORD_W-1:0] im_wdata;

    // Loader side: consumes bytes, produces memory writes.
    modport slave (
        input  in_valid,
        input  in_byte,
        output in_ready,
        output im_we,
        output im_addr,
        output im_wdata
    );

    // Host side: produces bytes, observes memory writes.
    modport master (
        output in_valid,
        output in_byte,
        input  in_ready,
        input  im_we,
        input  im_addr,
        input  im_wdata
    );

endinterface

// File: rtl/im_word_asm.sv
// Big-endian byte-to-word shift register with a 2-bit byte counter.
// Latency: word_valid pulses one cycle after the 4th byte is taken.
// Backpressure: none; the caller only asserts take on accepted bytes.
module im_word_asm
    import im_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 take,
    input  logic [7:0]           byte_in,
    output logic [IM_WORD_W-1:0] word,
    output logic                 word_valid
);

    logic [1:0]           cnt;
    logic [IM_WORD_W-1:0] shreg;

    // Shift each accepted byte in at the bottom so byte 0 ends up in [31:24].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 2'd0;
            shreg      <= '0;
            word_valid <= 1'b0;
        end else if (clr) begin
            cnt        <= 2'd0;
            shreg      <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= take && (cnt == 2'd3);
            if (take) begin
                shreg <= {shreg[IM_WORD_W-9:0], byte_in};
                cnt   <= cnt + 2'd1;
            end
        end
    end

    assign word = shreg;

endmodule

// File: rtl/im_loader.sv
// Loads a length-prefixed byte stream into instruction memory while holding the CPU.
// Latency: im_we one cycle after a word's 4th byte; done one cycle after the last write.
// Backpressure: in_ready drops for the im_we cycle (one bubble per word). Macro: IM_LOADER_CHECKSUM_EN.
module im_loader
    import im_pkg::*;
#(
    parameter int DEPTH  = IM_DEPTH_DEFAULT,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    im_loader_if.slave bus,
    output logic       cpu_hold,
    output logic       done,
    output logic       err
);

    im_state_t            state;
    im_state_t            state_nxt;
    logic [ADDR_W-1:0]    word_idx;
    logic [7:0]           len_q;
    logic                 err_q;
    logic                 err_set;
    logic                 sess_clr;
    logic                 ready;
    logic                 we;
    logic                 take;
    logic                 len_ok;
    logic                 last_word;
    logic                 word_valid;
    logic [IM_WORD_W-1:0] word;

`ifdef IM_LOADER_CHECKSUM_EN
    logic [7:0] sum_q;
    logic       csum_ok;

    // Sum of everything seen so far plus the trailing byte must wrap to zero.
    assign csum_ok = (sum_q + bus.in_byte) == 8'd0;
`endif

    assign take      = bus.in_valid && ready;
    assign len_ok    = (bus.in_byte != 8'd0) && (int'({24'd0, bus.in_byte}) <= DEPTH);
    assign last_word = (int'(word_idx) + 1) == int'({24'd0, len_q});

    // State register; reset aborts any session in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, handshake and write strobe.
    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        sess_clr  = 1'b0;
        ready     = 1'b0;
        we        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LEN;
                    sess_clr  = 1'b1;
                end
            end
            LEN: begin
                ready = 1'b1;
                if (bus.in_valid) begin
                    if (len_ok) begin
                        state_nxt = DATA;
                    end else begin
                        err_set   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                // The write cycle doubles as the per-word bubble.
                we    = word_valid;
                ready = !word_valid;
                if (word_valid && last_word) begin
`ifdef IM_LOADER_CHECKSUM_EN
                    state_nxt = CSUM;
`else
                    state_nxt = FIN;
`endif
                end
            end
`ifdef IM_LOADER_CHECKSUM_EN
            CSUM: begin
                ready = 1'b1;
                if (bus.in_valid) begin
                    if (csum_ok) begin
                        state_nxt = FIN;
                    end else begin
                        err_set   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
`endif
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Session bookkeeping: word count, write index and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_idx <= '0;
            len_q    <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            if (sess_clr) begin
                word_idx <= '0;
                err_q    <= 1'b0;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
            if ((state == LEN) && take) begin
                len_q <= bus.in_byte;
            end
            if (we) begin
                word_idx <= word_idx + ADDR_W'(1);
            end
        end
    end

`ifdef IM_LOADER_CHECKSUM_EN
    // Running 8-bit sum over the length byte and every data byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= 8'd0;
        end else if (sess_clr) begin
            sum_q <= 8'd0;
        end else if (take && ((state == LEN) || (state == DATA))) begin
            sum_q <= sum_q + bus.in_byte;
        end
    end
`endif

    im_word_asm u_word_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (sess_clr),
        .take       (take && (state == DATA)),
        .byte_in    (bus.in_byte),
        .word       (word),
        .word_valid (word_valid)
    );

    assign bus.in_ready = ready;
    assign bus.im_we    = we;
    assign bus.im_addr  = word_idx;
    assign bus.im_wdata = word;
    assign cpu_hold     = (state != IDLE);
    assign done         = (state == FIN);
    assign err          = err_q;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: cycle table for the basic load plus directed sequences.
// Latency: n/a.
// Backpressure: the byte driver holds each byte until in_ready accepts it.
module tb_im_loader;

    logic clk;
    logic rst_n;
    logic start;
    logic cpu_hold;
    logic done;
    logic err;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [7:0]  tb_sum = 8'd0;
    logic [4:0]  wa[$];
    logic [31:0] wd[$];

    im_loader_if #(.ADDR_W(5)) io ();

    im_loader #(.DEPTH(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus      (io),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every memory write and done pulse.
    always @(negedge clk) begin
        if (io.im_we === 1'b1) begin
            wa.push_back(io.im_addr);
            wd.push_back(io.im_wdata);
        end
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    typedef struct {
        logic        s;
        logic        v;
        logic [7:0]  d;
        logic        rdy;
        logic        we;
        logic [4:0]  a;
        logic [31:0] wdat;
        logic        h;
        logic        dn;
        logic        er;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic v, input logic [7:0] d,
                                input logic rdy, input logic we, input logic [4:0] a,
                                input logic [31:0] wdat, input logic h, input logic dn,
                                input logic er);
        vec_t r;
        r.s = s; r.v = v; r.d = d; r.rdy = rdy; r.we = we; r.a = a;
        r.wdat = wdat; r.h = h; r.dn = dn; r.er = er;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        wa.delete();
        wd.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start();
        io.in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tb_sum = 8'd0;
    endtask

    // Present one byte until accepted, then idle for gap cycles. Entered at a negedge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        io.in_valid = 1'b1;
        io.in_byte  = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = (io.in_ready === 1'b1);
            @(negedge clk);
        end
        io.in_valid = 1'b0;
        tb_sum = tb_sum + b;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL byte_accept: byte 0x%0h got no in_ready within 20 cycles", b);
        end
        repeat (gap) @(negedge clk);
    endtask

    // Trailing checksum byte when that build option is on; nothing otherwise.
    task automatic finish_stream();
`ifdef IM_LOADER_CHECKSUM_EN
        send_byte(8'd0 - tb_sum, 0);
`endif
    endtask

    task automatic check_basic_writes(input string tag);
        check({tag, "_nwr"}, 32'(wa.size()), 32'd2);
        if (wa.size() >= 2) begin
            check({tag, "_a0"}, 32'(wa[0]), 32'd0);
            check({tag, "_d0"}, wd[0], 32'h2008_0020);
            check({tag, "_a1"}, 32'(wa[1]), 32'd1);
            check({tag, "_d1"}, wd[1], 32'h2009_0027);
        end
        check({tag, "_done"}, 32'(done_cnt), 32'd1);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    endtask

    logic [7:0]  basic[9];
    logic [31:0] exp_w[$];
    logic [31:0] w;

    initial begin
        basic = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h20, 8'h20, 8'h09, 8'h00, 8'h27};
        rst_n = 1'b0;
        start = 1'b0;
        io.in_valid = 1'b0;
        io.in_byte  = 8'h00;

        // Basic load, one row per cycle: inputs driven, outputs expected in that cycle.
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h02, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h20, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h08, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h20, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h20, 0, 1, 0, 32'h2008_0020, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h20, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h09, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h27, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 32'h2009_0027, 1, 0, 0));
`ifdef IM_LOADER_CHECKSUM_EN
        vecs.push_back(mk(0, 1, 8'h66, 1, 0, 0, 0, 1, 0, 0));
`endif
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_rdy", 32'(io.in_ready), 32'd0);
        check("rst_we", 32'(io.im_we), 32'd0);
        check("rst_addr", 32'(io.im_addr), 32'd0);
        check("rst_wdata", io.im_wdata, 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        clear_mon();

        for (int i = 0; i < vecs.size(); i++) begin
            check($sformatf("vec%0d_rdy", i), 32'(io.in_ready), 32'(vecs[i].rdy));
            check($sformatf("vec%0d_we", i), 32'(io.im_we), 32'(vecs[i].we));
            check($sformatf("vec%0d_hold", i), 32'(cpu_hold), 32'(vecs[i].h));
            check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].dn));
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].er));
            if (vecs[i].we) begin
                check($sformatf("vec%0d_addr", i), 32'(io.im_addr), 32'(vecs[i].a));
                check($sformatf("vec%0d_wdata", i), io.im_wdata, vecs[i].wdat);
            end
            start       = vecs[i].s;
            io.in_valid = vecs[i].v;
            io.in_byte  = vecs[i].d;
            @(negedge clk);
        end
        start = 1'b0;
        io.in_valid = 1'b0;
        check("tbl_done_cnt", 32'(done_cnt), 32'd1);

        // Bad length 0x00, then 0x21 (one past DEPTH).
        clear_mon();
        pulse_start();
        check("len0_hold", 32'(cpu_hold), 32'd1);
        io.in_valid = 1'b1; io.in_byte = 8'h00;
        @(negedge clk);
        io.in_valid = 1'b0;
        check("len0_err", 32'(err), 32'd1);
        check("len0_hold_off", 32'(cpu_hold), 32'd0);
        check("len0_idle_rdy", 32'(io.in_ready), 32'd0);
        pulse_start();
        check("len21_err_clr", 32'(err), 32'd0);
        io.in_valid = 1'b1; io.in_byte = 8'h21;
        @(negedge clk);
        io.in_valid = 1'b0;
        check("len21_err", 32'(err), 32'd1);
        check("len21_hold_off", 32'(cpu_hold), 32'd0);
        repeat (2) @(negedge clk);
        check("len_err_sticky", 32'(err), 32'd1);
        check("len_nwr", 32'(wa.size()), 32'd0);
        check("len_ndone", 32'(done_cnt), 32'd0);

        // Basic stream with 3 idle cycles between bytes.
        clear_mon();
        pulse_start();
        foreach (basic[i]) send_byte(basic[i], 3);
        finish_stream();
        repeat (4) @(negedge clk);
        check_basic_writes("stall");

        // Full-depth load: 32 words, addresses 0..31 without wrap.
        clear_mon();
        exp_w.delete();
        pulse_start();
        send_byte(8'h20, 0);
        for (int i = 0; i < 32; i++) begin
            w = {8'(i), 8'hC3, 8'(i * 7), 8'h5A};
            exp_w.push_back(w);
            send_byte(w[31:24], 0);
            send_byte(w[23:16], 0);
            send_byte(w[15:8], 0);
            send_byte(w[7:0], 0);
        end
        finish_stream();
        repeat (4) @(negedge clk);
        check("full_nwr", 32'(wa.size()), 32'd32);
        for (int i = 0; i < 32 && i < wa.size(); i++) begin
            check($sformatf("full_a%0d", i), 32'(wa[i]), 32'(i));
            check($sformatf("full_d%0d", i), wd[i], exp_w[i]);
        end
        check("full_done", 32'(done_cnt), 32'd1);
        check("full_err", 32'(err), 32'd0);

        // Reset asserted after two data bytes.
        clear_mon();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h20, 0);
        send_byte(8'h08, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rdy", 32'(io.in_ready), 32'd0);
        check("mid_rst_we", 32'(io.im_we), 32'd0);
        check("mid_rst_addr", 32'(io.im_addr), 32'd0);
        check("mid_rst_wdata", io.im_wdata, 32'd0);
        check("mid_rst_hold", 32'(cpu_hold), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        io.in_valid = 1'b1; io.in_byte = 8'h02;
        repeat (2) @(negedge clk);
        io.in_valid = 1'b0;
        check("post_rst_rdy", 32'(io.in_ready), 32'd0);
        check("post_rst_hold", 32'(cpu_hold), 32'd0);

        // Start pulse in DATA is ignored; session completes unchanged.
        clear_mon();
        pulse_start();
        send_byte(basic[0], 0);
        send_byte(basic[1], 0);
        send_byte(basic[2], 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mid_start_hold", 32'(cpu_hold), 32'd1);
        for (int i = 3; i < 9; i++) send_byte(basic[i], 0);
        finish_stream();
        repeat (4) @(negedge clk);
        check_basic_writes("mid_start");

`ifdef IM_LOADER_CHECKSUM_EN
        // Checksum accepted: 01 + 01 + FE wraps to zero.
        clear_mon();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hFE, 0);
        repeat (4) @(negedge clk);
        check("csum_ok_nwr", 32'(wa.size()), 32'd1);
        if (wa.size() >= 1) begin
            check("csum_ok_a0", 32'(wa[0]), 32'd0);
            check("csum_ok_d0", wd[0], 32'h0000_0001);
        end
        check("csum_ok_done", 32'(done_cnt), 32'd1);
        check("csum_ok_err", 32'(err), 32'd0);

        // Checksum rejected.
        clear_mon();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hFF, 0);
        repeat (4) @(negedge clk);
        check("csum_bad_done", 32'(done_cnt), 32'd0);
        check("csum_bad_err", 32'(err), 32'd1);
        check("csum_bad_hold", 32'(cpu_hold), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning the number of 32-bit words in the instruction memory write target.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning the word-address width; it SHALL equal clog2(DEPTH).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a one-cycle pulse that begins a load session.
REQ-006 SHALL have port in_valid, input, 1, which marks in_byte as valid.
REQ-007 SHALL have port in_byte, input, 8, the byte-stream data.
REQ-008 SHALL have port in_ready, output, 1; a byte is accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port im_we, output, 1, the instruction-memory word write strobe.
REQ-010 SHALL have port im_addr, output, ADDR_W, the word index (byte address = im_addr*4).
REQ-011 SHALL have port im_wdata, output, 32, the instruction word to write.
REQ-012 SHALL have port cpu_hold, output, 1; while high, the CPU PC is held at 0.
REQ-013 SHALL have port done, output, 1, a one-cycle pulse on successful completion.
REQ-014 SHALL have port err, output, 1, sticky until the next start or reset.

Function
REQ-015 SHALL implement the FSM states IDLE, LEN, DATA, CSUM and FIN.
REQ-016 In IDLE, a start pulse SHALL move the FSM to LEN, clear err and assert cpu_hold; a start pulse in any other state SHALL be ignored.
REQ-017 In LEN, the first accepted byte SHALL be the word count N; if N==0 or N>DEPTH, the block SHALL set err and return to IDLE; otherwise it SHALL go to DATA.
REQ-018 In DATA, bytes SHALL be assembled big-endian: byte 0 goes to bits [31:24] and byte 3 goes to bits [7:0].
REQ-019 im_we SHALL pulse for exactly one cycle, the cycle after the 4th byte of a word is accepted, with im_wdata = the assembled word and im_addr = the word index, starting at 0 and incrementing by 1.
REQ-020 in_ready SHALL be high in LEN, DATA and CSUM, except in the im_we cycle, when it SHALL be low (one bubble per word).
REQ-021 After word N-1 is written, the FSM SHALL go to CSUM if the checksum macro is defined, otherwise to FIN.
REQ-022 FIN SHALL last one cycle: done=1, cpu_hold deasserts on the next cycle, then the FSM returns to IDLE.
REQ-023 A stall (in_valid low) SHALL NOT change state, the byte count or the partial word.
REQ-024 im_addr SHALL never wrap, because N is bounded by DEPTH.
REQ-025 On an error path, cpu_hold SHALL deassert together with the return to IDLE; words already written are not rolled back.

Reset
REQ-026 While rst_n is low, the FSM SHALL be in IDLE and in_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_hold=0, done=0 and err=0.
REQ-027 Reset asserted mid-session SHALL abort the session immediately; memory contents are then undefined, and the next session requires a new start.

Configuration
REQ-028 With macro IM_LOADER_CHECKSUM_EN defined, an 8-bit running sum of the N byte and all data bytes SHALL be kept, and the CSUM state SHALL accept one byte C.
REQ-029 With IM_LOADER_CHECKSUM_EN defined: if (sum + C) mod 256 == 0, the block SHALL go to FIN; otherwise it SHALL set err, produce no done pulse and return to IDLE.
REQ-030 With IM_LOADER_CHECKSUM_EN undefined, there SHALL be no CSUM state, no sum register and no trailing byte.

Structure
REQ-031 Package im_pkg SHALL hold the FSM state enum, the IM word width (32) and the DEPTH default, shared with the IM block.
REQ-032 The design SHALL contain one sub-module, im_word_asm: byte-to-word shift register with a 2-bit byte counter and a word_valid output.

Verification
REQ-033 Scenario, basic load: start, then bytes 02, 20,08,00,20, 20,09,00,27 (checksum off) -> im_we at addr 0 with 0x20080020, at addr 1 with 0x20090027, then done=1, err=0, cpu_hold low afterwards.
REQ-034 Scenario, bad length: start, N=0x00 -> err=1, im_we never asserted, FSM back in IDLE; repeat with N=0x21 -> err=1.
REQ-035 Scenario, stalls: the basic stream with in_valid low for 3 cycles between bytes -> identical writes and values, done=1 once.
REQ-036 Scenario, checksum on: N=01, 00,00,00,01, C=0xFE -> write at addr 0 of 0x00000001, done=1; same stream with C=0xFF -> err=1, no done.
REQ-037 Scenario, reset and start mid-session: rst_n low after 2 data bytes -> all outputs 0; start pulse in the DATA state -> ignored and the session continues unaffected.
